mdc_input_commutator: RTL and testbench
=======================================

// Module: mdc_input_commutator
// PURPOSE
//   Front-end feeder of the 32-point MDC FFT pipeline, the counterpart of the per-stage
//   commutators. Takes one serial complex sample stream in natural order. Emits the
//   dual-path stream the first radix-2 butterfly consumes: pairs (x[k], x[k+N/2]) on
//   Up/Low, for k = 0..N/2-1.
//   Uses an internal N/2-deep delay buffer and a frame-position state machine.
// PARAMETERS
//   WIDTH   9    bit width of each real/imag component (signed, two's complement)
//   N       32   FFT frame length in samples (power of two, >= 4)
//   CNT_W   5    log2(N); width of the in-frame sample counter
// PORTS
//   clk         in   1          rising-edge clock
//   rst         in   1          asynchronous, active-high reset
//   in_valid    in   1          input sample valid this cycle
//   in_sop      in   1          start of frame; qualified by in_valid; marks sample index 0
//   in_re       in   WIDTH      input sample real part (signed)
//   in_im       in   WIDTH      input sample imaginary part (signed)
//   out_valid   out  1          Up/Low pair valid this cycle
//   Up_out_re   out  WIDTH      x[k] real
//   Up_out_im   out  WIDTH      x[k] imag
//   Low_out_re  out  WIDTH      x[k+N/2] real
//   Low_out_im  out  WIDTH      x[k+N/2] imag
//   out_idx     out  CNT_W-1    pair index k, 0..N/2-1
//   out_last    out  1          high with out_valid on pair k = N/2-1
//   frame_err   out  1          one-cycle pulse: in_sop arrived with the frame incomplete
// BEHAVIOUR
// - Reset (async, rst=1): state=FILL, cnt=0. All outputs 0: out_valid, out_last,
//   frame_err, Up/Low, out_idx. Buffer RAM contents are not reset (don't-care).
// - cnt advances only on accepted samples (in_valid=1). Idle cycles hold all state.
//   Input gaps of any length are legal.
// - FILL state (cnt 0..N/2-1): write the sample to buf[cnt] and increment cnt.
//   out_valid stays 0.
//   When the write at cnt = N/2-1 completes, state goes to PAIR.
// - PAIR state (cnt N/2..N-1): on an accepted sample, the registered outputs take, next cycle:
//   Up = buf[cnt-N/2], Low = input sample, out_idx = cnt-N/2, out_valid = 1.
//   Latency: exactly 1 clk from the accepted second-half sample to out_valid.
//   At cnt = N-1, out_last=1. cnt wraps to 0 and state goes to FILL.
// - out_valid and out_last are single-cycle per pair.
//   Data outputs hold their last value when out_valid=0.
// - No arithmetic is performed; samples pass bit-exact. Widths are unchanged.
// - in_sop with in_valid:
//   - If cnt=0: normal frame start.
//   - Otherwise: abort the current frame (no further pairs from it). Pulse frame_err
//     next cycle. Treat this sample as index 0: write buf[0], cnt=1, state FILL.
// - in_sop without in_valid: ignored.
// - A sample with cnt=0 and no in_sop is accepted as index 0 (free-running framing).
// - Reset mid-frame discards the partial frame. The first accepted sample after reset is index 0.
// - Buffer read and write never collide: reads occur only in PAIR, writes only in FILL.
// TESTING
// 1. Continuous frame, in_sop on first sample, x[n]=n+j(-n), 32 back-to-back valids.
//    -> out_valid on cycles 17..32 after first sample. Pair k: Up=(k,-k), Low=(k+16,-k-16).
//    out_last with k=15.
// 2. Same frame with in_valid toggling 1,0,1,0.
//    -> identical 16 pairs, each out_valid one clk after its second-half sample. No pair during gaps.
// 3. Two back-to-back frames, 64 valids.
//    -> 32 pairs. Second frame starts at out_idx=0 with no bubble beyond the 16-sample fill.
// 4. in_sop at sample 20 of a frame.
//    -> frame_err pulses once, pairs k=0..3 emitted before it and none after. Next frame's
//    pairs start 16 samples after the in_sop.
// 5. Assert rst for 2 clks at sample 25, then a new frame.
//    -> outputs 0 immediately (async). The new frame's pairs are correct and frame_err stays 0.
// 6. Extremes: x = -256 / +255 components.
//    -> Up/Low reproduce the values bit-exact, with no sign corruption.

Source files
------------

// File: rtl/mdc_input_commutator.sv
// -----------------------------------------------------------------------------
// mdc_input_commutator
//
// Front-end feeder of the N-point MDC FFT pipeline. It accepts one serial
// complex sample stream in natural order and presents it to the first radix-2
// butterfly as a dual-path stream: pairs (x[k], x[k+N/2]) on Up/Low for
// k = 0..N/2-1.
//
// The first half of each frame is parked in an N/2-deep buffer (FILL). Each
// second-half sample is then paired with its buffered partner and both are
// registered onto the outputs one clock later (PAIR). Samples pass bit-exact.
//
// Parameters
//   WIDTH  bit width of each real/imag component (signed two's complement)
//   N      frame length in samples (power of two, >= 4)
//   CNT_W  log2(N), width of the in-frame sample counter
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in_valid    input sample valid this cycle
//   in_sop      start of frame, qualified by in_valid (sample index 0)
//   in_re/im    input sample real/imag part
//   out_valid   Up/Low pair valid this cycle (one cycle per pair)
//   Up_out_*    x[k]       (held while out_valid = 0)
//   Low_out_*   x[k+N/2]   (held while out_valid = 0)
//   out_idx     pair index k
//   out_last    high with out_valid on pair k = N/2-1
//   frame_err   one-cycle pulse: in_sop arrived with the frame incomplete
// -----------------------------------------------------------------------------
module mdc_input_commutator #(
  parameter int WIDTH = 9,
  parameter int N     = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_sop,
  input  logic [WIDTH-1:0]   in_re,
  input  logic [WIDTH-1:0]   in_im,
  output logic               out_valid,
  output logic [WIDTH-1:0]   Up_out_re,
  output logic [WIDTH-1:0]   Up_out_im,
  output logic [WIDTH-1:0]   Low_out_re,
  output logic [WIDTH-1:0]   Low_out_im,
  output logic [CNT_W-2:0]   out_idx,
  output logic               out_last,
  output logic               frame_err
);

  localparam int HALF = N / 2;
  localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(N - 1);

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  // Control decoded from the current position and the accepted sample.
  logic             wr_en;
  logic             pair_fire;
  logic             restart;
  logic [CNT_W-2:0] wr_addr;
  logic [CNT_W-2:0] rd_addr;

  // First-half sample storage.
  logic [WIDTH-1:0] mem_re [HALF];
  logic [WIDTH-1:0] mem_im [HALF];

  // ---------------------------------------------------------------------------
  // Frame position register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first; a path that skipped
  // one would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    wr_en      = 1'b0;
    pair_fire  = 1'b0;
    restart    = 1'b0;

    if (in_valid) begin
      if (in_sop && (cnt != '0)) begin
        // Early start of frame: drop the partial frame and take this sample
        // as index 0 of a fresh one.
        restart    = 1'b1;
        wr_en      = 1'b1;
        cnt_next   = CNT_W'(1);
        state_next = FILL;
      end else begin
        unique case (state)
          FILL: begin
            wr_en    = 1'b1;
            cnt_next = cnt + CNT_W'(1);
            if (cnt == LAST_FILL) state_next = PAIR;
          end
          PAIR: begin
            pair_fire = 1'b1;
            cnt_next  = cnt + CNT_W'(1);  // wraps to 0 after N-1
            if (cnt == LAST_PAIR) state_next = FILL;
          end
          default: state_next = FILL;
        endcase
      end
    end
  end

  // In FILL the low bits of cnt are the write slot; in PAIR (cnt >= N/2) the
  // same low bits equal cnt - N/2, the slot of the partner sample. A restart
  // always writes slot 0.
  assign wr_addr = restart ? '0 : cnt[CNT_W-2:0];
  assign rd_addr = cnt[CNT_W-2:0];

  // ---------------------------------------------------------------------------
  // Delay buffer. Written only in FILL, read only in PAIR, so there is never a
  // same-cycle read/write to resolve.
  // ---------------------------------------------------------------------------
  // NOTE: the buffer has no reset; its contents are always rewritten before
  // they are read, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_re[wr_addr] <= in_re;
      mem_im[wr_addr] <= in_im;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs: strobes pulse for one cycle per event, data and index
  // only load on a pair and hold otherwise.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_err  <= 1'b0;
      Up_out_re  <= '0;
      Up_out_im  <= '0;
      Low_out_re <= '0;
      Low_out_im <= '0;
      out_idx    <= '0;
    end else begin
      out_valid <= pair_fire;
      out_last  <= pair_fire && (cnt == LAST_PAIR);
      frame_err <= restart;
      if (pair_fire) begin
        Up_out_re  <= mem_re[rd_addr];
        Up_out_im  <= mem_im[rd_addr];
        Low_out_re <= in_re;
        Low_out_im <= in_im;
        out_idx    <= rd_addr;
      end
    end
  end

endmodule

// File: tb/tb_mdc_input_commutator.sv
// -----------------------------------------------------------------------------
// tb_mdc_input_commutator
//
// Directed bench for mdc_input_commutator (WIDTH=9, N=32). Each sample is
// driven for one clock and the outputs are sampled 1 time unit after that
// edge, where the pair produced by that sample (if any) must be visible.
// Expected pairs come from the in-frame position the stimulus assigns to each
// sample: position p >= 16 yields Up = sample at p-16, Low = sample at p,
// out_idx = p-16. Data/index expectations are held between pairs.
// -----------------------------------------------------------------------------
module tb_mdc_input_commutator;

  localparam int WIDTH = 9;
  localparam int N     = 32;
  localparam int CNT_W = 5;
  localparam int HALF  = N / 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_sop;
  logic        [WIDTH-1:0]  in_re;
  logic        [WIDTH-1:0]  in_im;
  logic                     out_valid;
  logic signed [WIDTH-1:0]  Up_out_re;
  logic signed [WIDTH-1:0]  Up_out_im;
  logic signed [WIDTH-1:0]  Low_out_re;
  logic signed [WIDTH-1:0]  Low_out_im;
  logic        [CNT_W-2:0]  out_idx;
  logic                     out_last;
  logic                     frame_err;

  int checks = 0;
  int errors = 0;

  // Samples sent at each in-frame position of the current frame.
  int sent_re [N];
  int sent_im [N];

  // Expected (held) data outputs.
  int h_ure = 0, h_uim = 0, h_lre = 0, h_lim = 0, h_idx = 0;

  mdc_input_commutator #(
    .WIDTH (WIDTH),
    .N     (N),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_re      (in_re),
    .in_im      (in_im),
    .out_valid  (out_valid),
    .Up_out_re  (Up_out_re),
    .Up_out_im  (Up_out_im),
    .Low_out_re (Low_out_re),
    .Low_out_im (Low_out_im),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic elast,
                            input logic eerr);
    check({tag, " out_valid"}, out_valid, ev);
    check({tag, " out_last"},  out_last,  elast);
    check({tag, " frame_err"}, frame_err, eerr);
    check({tag, " up_re"},     Up_out_re,  h_ure);
    check({tag, " up_im"},     Up_out_im,  h_uim);
    check({tag, " low_re"},    Low_out_re, h_lre);
    check({tag, " low_im"},    Low_out_im, h_lim);
    check({tag, " out_idx"},   out_idx,    h_idx);
  endtask

  // One accepted sample at in-frame position pos.
  task automatic send(input int pos, input logic sop, input int re, input int im,
                      input logic eerr);
    in_valid = 1'b1;
    in_sop   = sop;
    in_re    = WIDTH'(re);
    in_im    = WIDTH'(im);
    sent_re[pos] = re;
    sent_im[pos] = im;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    if (pos >= HALF) begin
      h_ure = sent_re[pos-HALF];
      h_uim = sent_im[pos-HALF];
      h_lre = re;
      h_lim = im;
      h_idx = pos - HALF;
    end
    check_outs($sformatf("pos%0d", pos), pos >= HALF, pos == N-1, eerr);
  endtask

  // One idle cycle; in_sop may be raised without in_valid and must be ignored.
  task automatic idle(input logic sop);
    in_valid = 1'b0;
    in_sop   = sop;
    @(posedge clk);
    #1;
    in_sop = 1'b0;
    check_outs("idle", 1'b0, 1'b0, 1'b0);
  endtask

  // Full frame x[n] = (base+n) + j(-(base+n)), optionally with idle gaps.
  task automatic frame(input int base, input logic sop_first, input logic gaps);
    for (int n = 0; n < N; n++) begin
      send(n, sop_first && (n == 0), base + n, -(base + n), 1'b0);
      if (gaps) idle(n == 5);
    end
  endtask

  task automatic clear_held();
    h_ure = 0; h_uim = 0; h_lre = 0; h_lim = 0; h_idx = 0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_re    = '0;
    in_im    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(1'b0);

    // 1: continuous frame x[n] = n - jn.
    frame(0, 1'b1, 1'b0);

    // 2: same frame with in_valid toggling; stray in_sop during a gap.
    frame(0, 1'b1, 1'b1);

    // 3: two back-to-back frames, second one free-running (no in_sop).
    frame(100, 1'b1, 1'b0);
    frame(200, 1'b0, 1'b0);

    // 4: in_sop at sample 20 aborts the frame after pairs k=0..3.
    for (int n = 0; n < 20; n++) send(n, n == 0, 10 + n, -(10 + n), 1'b0);
    send(0, 1'b1, 60, -60, 1'b1);
    for (int n = 1; n < N; n++) send(n, 1'b0, 60 + n, -(60 + n), 1'b0);
    idle(1'b0);

    // 5: async reset mid-frame, then a fresh frame.
    for (int n = 0; n < 25; n++) send(n, n == 0, 30 + n, -(30 + n), 1'b0);
    rst = 1'b1;
    #1;
    clear_held();
    check_outs("async_rst", 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_outs("rst_hold", 1'b0, 1'b0, 1'b0);
    frame(50, 1'b1, 1'b0);

    // 6: extreme component values.
    for (int n = 0; n < N; n++)
      send(n, n == 0, (n % 2) ? 255 : -256, (n % 2) ? -256 : 255, 1'b0);
    idle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
